// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional macro UART_TX_PARITY_EN adds the even-parity state to the FSM enum.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam logic IDLE_LEVEL     = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
// Held at zero by clear so the first bit of a frame is full length.
module uart_baud_gen #(
  parameter int BIT_CYCLES = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per start request, 8N1 (8E1 with UART_TX_PARITY_EN).
// state    | meaning
// IDLE     | line high, waiting for start
// START    | start bit (tx=0)
// DATA     | eight data bits, LSB first
// PARITY   | even parity bit (only with UART_TX_PARITY_EN)
// STOP     | stop bit (tx=1), done pulses on exit
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;

  tx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       bit_tick;
  logic       timer_clear;
`ifdef UART_TX_PARITY_EN
  logic       parity;
`endif

  // Timer parked at zero while idle, so it starts fresh on the accepting edge.
  assign timer_clear = (state == S_IDLE);

  uart_baud_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg   <= data;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= S_START;
`ifdef UART_TX_PARITY_EN
            parity  <= ^data;
`endif
          end
        end
        S_START: begin
          if (bit_tick) begin
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= S_PARITY;
`else
              tx    <= IDLE_LEVEL;
              state <= S_STOP;
`endif
            end else begin
              tx <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            tx    <= IDLE_LEVEL;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_tick) begin
            tx    <= IDLE_LEVEL;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter stage that consumes one byte at a time from the character-sequencing stage and shifts it out as an 8N1 UART frame (8E1 when parity is compiled in). It accepts a byte on a `start` request, drives the `tx` line bit by bit at the configured baud rate, and emits a single-cycle `done` pulse when the stop bit ends. `done` drives the sequencer's `valid` input so the sequencer advances to the next character.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `BIT_CYCLES`, derived as CLK_FREQ/BAUD with integer division (10416 at defaults); must be at least 2.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: transmit request; sampled only in IDLE.
- `data` input, 8 bits: byte to send; captured on the accepting edge.
- `tx` output, 1 bit: serial line, idle high.
- `busy` output, 1 bit: high while a frame is in progress.
- `done` output, 1 bit: one-cycle pulse at frame end.

## Operation
- Reset values, applied asynchronously:
  - `tx`=1, `busy`=0, `done`=0.
  - State IDLE; bit counter, cycle counter and shift register all cleared.
- FSM states are IDLE, START, DATA, PARITY (only when compiled in) and STOP.
- IDLE:
  - When `start`=1, latch `data` into the shift register, clear the cycle counter and go to START.
  - Otherwise remain in IDLE.
- START: `tx`=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA:
  - `tx` = shift register bit 0 (LSB first).
  - After BIT_CYCLES cycles, shift right and increment the bit index.
  - After index 7 completes, go to PARITY if compiled in, otherwise STOP.
- STOP: `tx`=1 for BIT_CYCLES cycles, then go to IDLE with `done`=1 for that one cycle.
- `busy`=1 in every state except IDLE.
- The cycle counter is $clog2(BIT_CYCLES) bits wide and counts 0 to BIT_CYCLES-1, then wraps to 0 on each bit boundary.
- Boundary conditions:
  - `start` while `busy`=1 is ignored; there is no queueing.
  - Changes to `data` after acceptance do not affect the frame in progress.
  - `start` held high continuously produces back-to-back frames. Each frame is accepted the cycle after the previous `done`, once the FSM has returned to IDLE.
  - Reset mid-frame aborts the frame: `tx` returns high immediately and no `done` is issued.

## Timing
- `start` is sampled at edge T:
  - At T+1, `tx`=0 and `busy`=1.
  - The start bit occupies cycles T+1 through T+BIT_CYCLES.
- Each data bit i occupies BIT_CYCLES cycles, beginning at T+1+(i+1)·BIT_CYCLES.
- Frame length is 10·BIT_CYCLES cycles, or 11·BIT_CYCLES with parity.
- `done` and `busy`=0 occur together at T+1+10·BIT_CYCLES (T+1+11·BIT_CYCLES with parity), and `tx` stays high.
- The upstream sequencer registers its next byte one cycle after `done`. The controller issuing `start` waits at least 2 cycles after `done`.
- `tx`, `busy` and `done` are all registered outputs and are glitch-free.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- When defined:
  - The PARITY state is inserted between DATA and STOP.
  - It drives `tx` with the even-parity bit (XOR of the 8 latched bits) for BIT_CYCLES cycles.
- When undefined, the PARITY state, its logic and its parity register are absent, and the frame is 8N1.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - default CLK_FREQ and BAUD constants;
  - the IDLE_LEVEL (1) constant.
- Sub-module `uart_baud_gen`:
  - takes clk, rst and a clear input, and produces a one-cycle `bit_tick` every BIT_CYCLES cycles;
  - is cleared on frame start so the first bit is full length.

## Test plan
- Send 0x68 with CLK_FREQ=8, BAUD=1 (BIT_CYCLES=8):
  - `tx` = 0 (start), then 0,0,0,1,0,1,1,0, then 1 (stop), each level for 8 cycles.
  - `done` pulses exactly at T+81.
- Reset checks:
  - Assert `rst` during data bit 3: `tx`=1 and `busy`=0 asynchronously, with no `done`.
  - After release, a new `start` sends a full correct frame.
- Pulse `start` with 0x55 while `busy`=1 mid-frame: that pulse is ignored, and the current frame and the `done` count are unaffected.
- Hold `start` high with `data` stepping 0x68, 0x69, 0x74: three consecutive frames are produced, each start bit beginning one cycle after the previous `done`.
- With `UART_TX_PARITY_EN` defined:
  - 0x68 gives parity bit 1 and 0x69 gives parity bit 0.
  - `done` pulses at T+89.
- Idle check: no `start` for 100 cycles after reset gives `tx`=1, `busy`=0 and `done`=0 throughout.
